// File: rtl/tick_down_counter.sv
// Loadable, pausable down-counter driven by an internal tick prescaler.
// Decrements once per TICK_DIV run cycles and pulses done on reaching zero.
module tick_down_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          advance;
  logic          presc_last;
  logic          last_count;

  // A resume edge counts as a run edge, so a frozen terminal prescale fires on it.
  always_comb begin
    advance    = ((state == RUN) && !pause) || ((state == PAUSED) && start);
    presc_last = (presc == PRESC_LAST);
    last_count = (count == WIDTH'(1));
  end

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      presc <= '0;
      tick  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (load) begin
        count <= load_val;
        presc <= '0;
        state <= IDLE;
        busy  <= 1'b0;
      end else if (state == IDLE) begin
        if (start && !zero) begin
          state <= RUN;
          presc <= '0;
          busy  <= 1'b1;
        end
      end else if ((state == RUN) && pause) begin
        state <= PAUSED;
      end else if (advance) begin
        state <= RUN;
        busy  <= 1'b1;
        if (presc_last) begin
          presc <= '0;
          count <= count - WIDTH'(1);
          tick  <= 1'b1;
          if (last_count) begin
            done  <= 1'b1;
            state <= DONE;
            busy  <= 1'b0;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_down_counter.sv
// Bench for tick_down_counter: directed scenarios with literal expectations,
// then randomized strobes checked every cycle against a behavioural model.
module tb_tick_down_counter;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned TICK_DIV = 4;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             busy;
  logic             done;
  logic             zero;

  int checks   = 0;
  int failures = 0;

  int m_mode  = M_IDLE;
  int m_count = 0;
  int m_run   = 0;
  int m_tick  = 0;
  int m_done  = 0;

  tick_down_counter #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .count(count), .tick(tick),
    .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: m_run counts cycles spent running since the last decrement.
  always @(posedge clk) begin
    m_tick = 0;
    m_done = 0;
    if (!rst) begin
      m_mode = M_IDLE; m_count = 0; m_run = 0;
    end else if (load) begin
      m_count = int'(load_val); m_run = 0; m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (start && m_count != 0) begin m_mode = M_RUN; m_run = 0; end
    end else if (m_mode == M_RUN && pause) begin
      m_mode = M_PAUSED;
    end else if (m_mode == M_RUN || (m_mode == M_PAUSED && start)) begin
      m_mode = M_RUN;
      m_run  = m_run + 1;
      if (m_run == TICK_DIV) begin
        m_run   = 0;
        m_count = (m_count + 15) % 16;
        m_tick  = 1;
        if (m_count == 0) begin m_done = 1; m_mode = M_DONE; end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("count", 32'(count), 32'(m_count));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'((m_mode == M_RUN || m_mode == M_PAUSED) ? 1 : 0));
    chk("zero", 32'(zero), 32'((m_count == 0) ? 1 : 0));
  endtask

  // One clock: drive inputs, take the edge, then compare at the falling edge.
  task automatic cyc(input logic r, input logic l, input logic [WIDTH-1:0] lv,
                     input logic s, input logic p);
    rst = r; load = l; load_val = lv; start = s; pause = p;
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int nt;
    int nd;

    // Reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("rst_count", 32'(count), 0);
      chk("rst_zero", 32'(zero), 1);
      chk("rst_busy", 32'(busy), 0);
    end

    // Full countdown from 3
    cyc(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("cd_busy_start", 32'(busy), 1);
    nt = 0;
    for (int i = 1; i <= 12; i++) begin
      idle();
      nt += int'(tick);
      if (i == 4)  chk("cd_count_n4", 32'(count), 2);
      if (i == 8)  chk("cd_count_n8", 32'(count), 1);
      if (i == 11) chk("cd_done_early", 32'(done), 0);
      if (i == 12) begin
        chk("cd_count_n12", 32'(count), 0);
        chk("cd_done", 32'(done), 1);
        chk("cd_busy_end", 32'(busy), 0);
      end
    end
    chk("cd_ticks", 32'(nt), 3);
    idle();
    chk("cd_done_once", 32'(done), 0);

    // Start in DONE is ignored
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) idle();
    chk("done_start_count", 32'(count), 0);
    chk("done_start_busy", 32'(busy), 0);

    // Pause and resume
    cyc(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 18; i++) begin
      if (i == 6) cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
      else if (i == 16) cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
      else idle();
      if (i == 15) begin
        chk("pz_frozen", 32'(count), 4);
        chk("pz_busy", 32'(busy), 1);
      end
      if (i == 17) chk("pz_n17", 32'(count), 4);
      if (i == 18) begin
        chk("pz_n18", 32'(count), 3);
        chk("pz_tick", 32'(tick), 1);
      end
    end

    // Pause collides with terminal prescale
    cyc(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      if (i == 4) cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
      else if (i == 7) cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
      else idle();
      if (i == 4) begin
        chk("col_count", 32'(count), 2);
        chk("col_tick", 32'(tick), 0);
      end
      if (i == 7) begin
        chk("col_resume", 32'(count), 1);
        chk("col_resume_tick", 32'(tick), 1);
      end
    end

    // Load during RUN
    cyc(1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) idle();
    chk("ld_pre", 32'(count), 6);
    cyc(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
    chk("ld_count", 32'(count), 2);
    chk("ld_busy", 32'(busy), 0);
    chk("ld_done", 32'(done), 0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      nd += int'(done);
    end
    chk("ld_dones", 32'(nd), 1);
    chk("ld_final", 32'(count), 0);

    // Start with count 0 in IDLE is ignored
    cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("z_start_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++) idle();
    chk("z_start_tick", 32'(tick), 0);

    // Reset mid-RUN right as a tick is produced
    cyc(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle();
    chk("mr_tick", 32'(tick), 1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("mr_count", 32'(count), 0);
    chk("mr_tick_clr", 32'(tick), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_zero", 32'(zero), 1);

    // Randomized strobes
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic rv, lv, sv, pv;
      r  = int'($urandom_range(0, 199));
      rv = (r != 0);
      lv = ($urandom_range(0, 99) < 4);
      sv = ($urandom_range(0, 99) < 15);
      pv = ($urandom_range(0, 99) < 6);
      cyc(rv, lv, WIDTH'($urandom_range(0, 15)), sv, pv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_down_counter.md
# tick_down_counter

- Loadable, pausable down-counter that counts once per prescaled tick and flags terminal count.
- Sits in the downcounter datapath directly downstream of the 1 Hz tick-enable register stage.
- Combines that stage's prescaler with a run-control FSM, a count register and a single-cycle `done` pulse.
- The outputs feed the display and terminal-count logic.

## Interface

Parameters:
- `WIDTH`, 4: count register width in bits.
- `TICK_DIV`, 100_000_000: clk cycles per tick. Must be ≥ 2. Prescaler width is clog2(TICK_DIV).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset. Sampled on the `clk` rising edge; 0 resets the block.
- `load`  in  1  one-cycle strobe: copy `load_val` into `count`.
- `load_val`  in  WIDTH  value to load.
- `start`  in  1  one-cycle strobe: start from IDLE, or resume from PAUSED.
- `pause`  in  1  one-cycle strobe: suspend counting while in RUN.
- `count`  out  WIDTH  current count (registered).
- `tick`  out  1  registered pulse, high for the one cycle after each decrement.
- `busy`  out  1  high in RUN or PAUSED.
- `done`  out  1  registered pulse, high for one cycle when count reaches 0 from RUN.
- `zero`  out  1  `count` == 0 (decoded from the register, no extra latency).

## Operation

- **Reset** (`rst`=0 at an edge): state=IDLE, `count`=0, prescaler=0, `tick`=0, `done`=0. Therefore `busy`=0 and `zero`=1.
- **FSM states:** IDLE, RUN, PAUSED, DONE.
- **Input priority per edge:** `load` > `pause` > `start` > tick event.
- **`load`, any state:**
  - `count`←`load_val`, prescaler←0, state→IDLE.
  - `tick` and `done` are 0 that cycle, so a load during RUN never produces `done`.
- **IDLE:**
  - `start` with `count`≠0 → RUN, prescaler←0.
  - `start` with `count`=0 is ignored; stay in IDLE.
  - `pause` is ignored.
- **RUN:**
  - The prescaler increments each cycle.
  - At prescaler=TICK_DIV−1: prescaler←0, `count`←`count`−1, `tick`←1.
  - If `count` was 1 at that edge, also `done`←1 and state→DONE.
  - `pause` → PAUSED, and it blocks any decrement on the same edge.
- **PAUSED:**
  - Prescaler and `count` frozen.
  - `start` → RUN. The prescaler resumes from its frozen value; it is not cleared.
  - `pause` is ignored.
- **DONE:**
  - `count` holds 0.
  - `start` and `pause` are ignored; only `load` or reset leaves DONE.
- **Arithmetic:** decrement is unsigned modulo 2^WIDTH. Underflow cannot occur, because RUN is never entered or held with `count`=0.
- **`load_val`=0 while running:** the block goes to IDLE with `count`=0 and no `done`.

## Timing

- A `start` accepted at edge N puts the FSM in RUN from edge N.
- Decrements occur at edges N+TICK_DIV, N+2·TICK_DIV, and so on, with `tick` high in the cycle after each of those edges.
- Loading L then starting:
  - `count` reaches 0 at edge N+L·TICK_DIV.
  - `done`=1 and `busy`=0 in the following cycle.
  - `done` is high for exactly 1 cycle.
- **Pause accounting:**
  - Pausing for P cycles delays every later decrement by exactly P+1 cycles: the pause edge plus P cycles in PAUSED.
  - More precisely, only cycles spent in RUN advance the prescaler.
- **Pause colliding with terminal prescale:** a `pause` on the edge where prescaler=TICK_DIV−1 suppresses that decrement. The prescaler freezes at TICK_DIV−1, so the decrement fires on the first RUN edge after resume.
- **`load` and reset:** both take effect at the sampled edge. Outputs reflect the new state one cycle later; there is no combinational path from inputs to outputs.
- **Reset mid-operation:** any in-flight `tick` or `done` is cleared.

## Test plan

All scenarios use `TICK_DIV`=4 and `WIDTH`=4.

1. **Reset values:** hold `rst`=0 for 3 cycles with `start`=1 → `count`=0, `zero`=1, `busy`=0, `tick`=0, `done`=0 throughout.
2. **Full countdown:** `load_val`=3 with `load`, then `start` at edge N →
   - `count` becomes 2/1/0 at edges N+4/N+8/N+12;
   - 3 `tick` pulses;
   - `done`=1 for one cycle after N+12;
   - `busy`=0 from N+12 onward.
3. **Pause and resume:** load 5, start at N, `pause` at N+6, `start` at N+16 →
   - `count`=4 frozen during the pause;
   - the next decrement (to 3) at edge N+18, i.e. 10 cycles later than the unpaused N+8.
4. **Pause/tick collision:** load 2, start at N, `pause` at N+4 →
   - `count` stays 2, no `tick`;
   - resume at N+7 → `count`=1 at edge N+7.
5. **Load during RUN:** load 9, start, then at count=6 assert `load` with `load_val`=2 →
   - `count`=2, state IDLE, `busy`=0, no `done`;
   - a subsequent `start` counts 2→0 with exactly one `done`.
6. **Ignored starts:**
   - `start` with `count`=0 in IDLE → remains IDLE, no `tick`.
   - `start` in DONE → `count` stays 0, no second `done`.
   - `rst`=0 asserted mid-RUN → all outputs return to their reset values the next cycle.
